// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD arithmetic datapaths: digit width, the largest
// legal digit value, the serial-subtractor state encoding and a digit check.
package bcd_pkg;

  localparam int              DIGIT_W   = 4;
  localparam logic [3:0]      BCD_MAX   = 4'd9;
  localparam logic [3:0]      BCD_RADIX = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic digit_valid(input logic [DIGIT_W-1:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of subtraction: diff = a - b - borrow_in, folded back into 0..9
// with a +10 correction whenever the binary difference goes negative.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] diff,
  output logic               borrow_out
);

  logic [DIGIT_W:0] raw;

  // The extra top bit of the widened difference is the sign, i.e. the borrow.
  always_comb begin
    raw        = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, borrow_in};
    borrow_out = raw[DIGIT_W];
    diff       = borrow_out ? raw[DIGIT_W-1:0] + BCD_RADIX : raw[DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: A - B one digit per clock, LSD first, returning
// sign-magnitude; a second serial pass ten's-complements a negative difference.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int DW     = DIGIT_W * DIGITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          neg,
  output logic          err
);

  localparam int            CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          borrow_q, borrow_d;
  logic          busy_q, busy_d, done_q, done_d, neg_q, neg_d, err_q, err_d;

  logic               ops_valid;
  logic [DIGIT_W-1:0] sub_a, sub_b, sub_diff;
  logic               sub_borrow;

  always_comb begin
    ops_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_valid(A[DIGIT_W*i +: DIGIT_W]) || !digit_valid(B[DIGIT_W*i +: DIGIT_W]))
        ops_valid = 1'b0;
    end
  end

  // One digit slice is shared: SUB feeds A_k - B_k, NEG feeds 0 - result_k.
  always_comb begin
    if (state_q == NEG) begin
      sub_a = '0;
      sub_b = result_q[DIGIT_W*int'(cnt_q) +: DIGIT_W];
    end else begin
      sub_a = a_q[DIGIT_W*int'(cnt_q) +: DIGIT_W];
      sub_b = b_q[DIGIT_W*int'(cnt_q) +: DIGIT_W];
    end
  end

  bcd_digit_sub u_digit_sub (
    .a          (sub_a),
    .b          (sub_b),
    .borrow_in  (borrow_q),
    .diff       (sub_diff),
    .borrow_out (sub_borrow)
  );

  always_comb begin
    // NOTE: every _d starts from its hold value so no path leaves it unassigned (no latches).
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    neg_d    = neg_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          result_d = '0;
          neg_d    = 1'b0;
          err_d    = 1'b0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          if (!ops_valid) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            busy_d  = 1'b1;
            state_d = SUB;
          end
        end
      end

      SUB, NEG: begin
        result_d[DIGIT_W*int'(cnt_q) +: DIGIT_W] = sub_diff;
        borrow_d = sub_borrow;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          borrow_d = 1'b0;
          // A final SUB borrow means A < B; the NEG pass's final borrow is dropped.
          if (state_q == SUB && sub_borrow) begin
            neg_d   = 1'b1;
            state_d = NEG;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign neg    = neg_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Randomized and directed checks of bcd_serial_subtractor against an
// integer-arithmetic reference model of BCD sign-magnitude subtraction.
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;
  localparam int DW     = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] a_in = '0;
  logic [DW-1:0] b_in = '0;
  logic          busy, done, neg, err;
  logic [DW-1:0] result;

  int n_checks = 0;
  int n_errors = 0;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (a_in),
    .B      (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .neg    (neg),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit bcd_ok(input logic [DW-1:0] v);
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd_to_int(input logic [DW-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [DW-1:0] int_to_bcd(input int v);
    logic [DW-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_bcd();
    logic [DW-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(9));
    return r;
  endfunction

  // Runs one operation; with noisy=1, start is held high with junk operands
  // throughout the operation, including the done cycle.
  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit noisy);
    logic [DW-1:0] exp_res;
    bit            exp_neg, exp_err, got_done;
    int            exp_lat, exp_busy, cyc, busy_cnt, diff;

    exp_err = !(bcd_ok(a) && bcd_ok(b));
    diff    = bcd_to_int(a) - bcd_to_int(b);
    exp_neg = !exp_err && (diff < 0);
    exp_res = exp_err ? '0 : int_to_bcd(exp_neg ? -diff : diff);
    exp_lat  = exp_err ? 1 : (exp_neg ? 2*DIGITS + 1 : DIGITS + 1);
    exp_busy = exp_err ? 0 : (exp_neg ? 2*DIGITS : DIGITS);

    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a_in = rand_bcd(); b_in = rand_bcd();

    cyc = 0; busy_cnt = 0; got_done = 1'b0;
    while (!got_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (done) got_done = 1'b1;
      if (noisy) begin
        start = 1'b1;
        a_in = rand_bcd(); b_in = rand_bcd();
      end
    end
    check("done_seen", 32'(got_done), 32'd1);
    check("latency", 32'(cyc), 32'(exp_lat));
    check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    check("result", 32'(result), 32'(exp_res));
    check("neg", 32'(neg), 32'(exp_neg));
    check("err", 32'(err), 32'(exp_err));

    @(negedge clk);
    start = 1'b0;
    check("done_pulse_end", 32'(done), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);
    check("result_held", 32'(result), 32'(exp_res));
    check("neg_held", 32'(neg), 32'(exp_neg));
  endtask

  initial begin
    bit saw_done;
    logic [DW-1:0] ra, rb;

    rst = 1'b1;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_neg", 32'(neg), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    run_op(16'h0042, 16'h0017, 1'b0);
    run_op(16'h0017, 16'h0042, 1'b0);
    run_op(16'h1000, 16'h0001, 1'b0);
    run_op(16'h0000, 16'h9999, 1'b0);
    run_op(16'h5555, 16'h5555, 1'b0);
    run_op(16'h9999, 16'h0000, 1'b0);
    run_op(16'h00A1, 16'h0000, 1'b0);
    run_op(16'h0003, 16'h0007, 1'b0);
    run_op(16'h1234, 16'h00F0, 1'b0);
    run_op(16'h0017, 16'h0042, 1'b1);
    run_op(16'h0042, 16'h0017, 1'b1);

    for (int n = 0; n < 40; n++) begin
      ra = rand_bcd();
      rb = ($urandom_range(3) == 0) ? ra : rand_bcd();
      if ($urandom_range(9) == 0) ra[4*$urandom_range(DIGITS-1) +: 4] = 4'($urandom_range(15, 10));
      run_op(ra, rb, 1'($urandom_range(1)));
    end

    // Asynchronous reset in the middle of the NEG pass.
    @(negedge clk);
    a_in = 16'h0017; b_in = 16'h0042; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_neg_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_neg", 32'(neg), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("no_done_after_abort", 32'(saw_done), 32'd0);
    run_op(16'h0017, 16'h0042, 1'b0);
    run_op(16'h0250, 16'h0125, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
